// File: rtl/fp64_pkg.sv
// Shared IEEE-754 binary64 field definitions and class-flag type for the
// floating-point component library.
package fp64_pkg;

    localparam int SIGN_BIT  = 63;
    localparam int EXP_MSB   = 62;
    localparam int EXP_LSB   = 52;
    localparam int MAN_MSB   = 51;
    localparam int QUIET_BIT = 51;

    localparam logic [EXP_MSB-EXP_LSB:0] EXP_ALL_ONES = 11'h7FF;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic subnormal;
    } fp64_class_t;

    // Class of +0.0, the value every pipeline stage holds after reset.
    localparam fp64_class_t CLASS_RESET = '{nan: 1'b0, inf: 1'b0, zero: 1'b1, subnormal: 1'b0};

    function automatic logic [EXP_MSB-EXP_LSB:0] fp64_exp(input logic [63:0] value);
        return value[EXP_MSB:EXP_LSB];
    endfunction

    function automatic logic [MAN_MSB:0] fp64_man(input logic [63:0] value);
        return value[MAN_MSB:0];
    endfunction

    // Signalling NaN: all-ones exponent, quiet bit clear, remaining payload nonzero.
    function automatic logic fp64_is_snan(input logic [63:0] value);
        return (fp64_exp(value) == EXP_ALL_ONES) && !value[QUIET_BIT]
            && (value[QUIET_BIT-1:0] != '0);
    endfunction

endpackage

// File: rtl/fp64_classify.sv
// Combinational binary64 classifier: flags NaN, infinity, zero and subnormal.
// Normal numbers leave every flag low; at most one flag is ever set.
module fp64_classify
    import fp64_pkg::*;
(
    input  logic [63:0]  value,
    output fp64_class_t  cls
);

    logic exp_ones;
    logic exp_zero;
    logic man_zero;

    assign exp_ones = (fp64_exp(value) == EXP_ALL_ONES);
    assign exp_zero = (fp64_exp(value) == '0);
    assign man_zero = (fp64_man(value) == '0);

    assign cls.nan       = exp_ones && !man_zero;
    assign cls.inf       = exp_ones &&  man_zero;
    assign cls.zero      = exp_zero &&  man_zero;
    assign cls.subnormal = exp_zero && !man_zero;

endmodule

// File: rtl/double_neg.sv
// Pipelined binary64 negation with optional signalling-NaN quietening and
// registered result class flags aligned with the final data stage.
module double_neg
    import fp64_pkg::*;
#(
    parameter int LATENCY   = 1,
    parameter bit QUIET_NAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] double_neg_a,
    output logic [63:0] double_neg_z,
    output logic        z_is_nan,
    output logic        z_is_inf,
    output logic        z_is_zero,
    output logic        z_is_subnormal,
    output logic        z_sign
);

    logic [63:0] neg_a;
    logic [63:0] pipe [LATENCY];
    logic [63:0] final_in;
    fp64_class_t final_cls;
    fp64_class_t cls_q;

    always_comb begin
        neg_a = {~double_neg_a[SIGN_BIT], double_neg_a[EXP_MSB:0]};
        if (QUIET_NAN && fp64_is_snan(double_neg_a)) begin
            neg_a[QUIET_BIT] = 1'b1;
        end
    end

    // NOTE: every stage is a plain register with a reset value, so non-blocking
    // assignment lets the shift happen in one edge regardless of loop order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= neg_a;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Flags are classified from whatever enters the last stage, so they land
    // on the same edge as the data they describe.
    generate
        if (LATENCY == 1) begin : g_single
            assign final_in = neg_a;
        end else begin : g_multi
            assign final_in = pipe[LATENCY-2];
        end
    endgenerate

    fp64_classify u_classify (
        .value (final_in),
        .cls   (final_cls)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cls_q <= CLASS_RESET;
        end else begin
            cls_q <= final_cls;
        end
    end

    assign double_neg_z   = pipe[LATENCY-1];
    assign z_is_nan       = cls_q.nan;
    assign z_is_inf       = cls_q.inf;
    assign z_is_zero      = cls_q.zero;
    assign z_is_subnormal = cls_q.subnormal;
    assign z_sign         = double_neg_z[SIGN_BIT];

endmodule

// File: tb/tb_double_neg.sv
// Self-checking bench for double_neg: two instances (LATENCY=1/QUIET_NAN=0 and
// LATENCY=3/QUIET_NAN=1) checked every cycle against a behavioural model.
module tb_double_neg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a = '0;

    logic [63:0] z1, z3;
    logic        nan1, inf1, zero1, sub1, sign1;
    logic        nan3, inf3, zero3, sub3, sign3;

    int n_checks = 0;
    int n_fail   = 0;

    // Most recent sampled inputs and reset levels, index 0 = newest edge.
    logic [63:0] h_a [$];
    bit          h_r [$];

    always #5 clk = ~clk;

    double_neg #(.LATENCY(1), .QUIET_NAN(1'b0)) u_l1 (
        .clk(clk), .rst_n(rst_n), .double_neg_a(a), .double_neg_z(z1),
        .z_is_nan(nan1), .z_is_inf(inf1), .z_is_zero(zero1),
        .z_is_subnormal(sub1), .z_sign(sign1)
    );

    double_neg #(.LATENCY(3), .QUIET_NAN(1'b1)) u_l3 (
        .clk(clk), .rst_n(rst_n), .double_neg_a(a), .double_neg_z(z3),
        .z_is_nan(nan3), .z_is_inf(inf3), .z_is_zero(zero3),
        .z_is_subnormal(sub3), .z_sign(sign3)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] neg_model(input logic [63:0] v, input bit quiet);
        logic [63:0] r;
        r = v ^ 64'h8000_0000_0000_0000;
        if (quiet && v[62:52] == 11'h7FF && v[51] == 1'b0 && v[50:0] != 0)
            r = r | 64'h0008_0000_0000_0000;
        return r;
    endfunction

    // {nan, inf, zero, subnormal, sign}
    function automatic logic [4:0] flags_model(input logic [63:0] v);
        bit ones, zexp, zman;
        ones = (v[62:52] == 11'h7FF);
        zexp = (v[62:52] == 11'h000);
        zman = (v[51:0] == 0);
        return {ones && !zman, ones && zman, zexp && zman, zexp && !zman, v[63]};
    endfunction

    function automatic logic [63:0] rand_double();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v[62:52] = 11'h000;
            1: v[62:52] = 11'h7FF;
            2: begin v[62:52] = 11'h7FF; v[51:0] = '0; end
            3: begin v[62:52] = 11'h7FF; v[51] = 1'b0; end
            4: v[62:0] = '0;
            default: ;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        h_a.push_front(a);
        h_r.push_front(rst_n);
        if (h_a.size() > 4) begin
            void'(h_a.pop_back());
            void'(h_r.pop_back());
        end
    end

    task automatic compare_inst(input string nm, input int lat, input bit quiet,
                                input logic [63:0] z, input logic [4:0] f);
        logic [63:0] ez;
        bit in_reset;
        in_reset = 1'b0;
        for (int i = 0; i < lat; i++) if (!h_r[i]) in_reset = 1'b1;
        ez = in_reset ? 64'h0 : neg_model(h_a[lat-1], quiet);
        check({nm, "_z"}, z, ez);
        check({nm, "_flags"}, {59'd0, f}, {59'd0, flags_model(ez)});
    endtask

    always @(negedge clk) begin
        if (h_a.size() >= 3) begin
            compare_inst("l1", 1, 1'b0, z1, {nan1, inf1, zero1, sub1, sign1});
            compare_inst("l3", 3, 1'b1, z3, {nan3, inf3, zero3, sub3, sign3});
        end
    end

    // Hold a value long enough for both instances to show it, then pin literals.
    task automatic directed(input logic [63:0] v, input logic [63:0] ez1,
                            input logic [4:0] ef1, input logic [63:0] ez3);
        @(negedge clk);
        a = v;
        repeat (3) @(posedge clk);
        #1;
        check("dir_l1_z", z1, ez1);
        check("dir_l1_flags", {59'd0, nan1, inf1, zero1, sub1, sign1}, {59'd0, ef1});
        check("dir_l3_z", z3, ez3);
    endtask

    initial begin
        check("pin_model_q", neg_model(64'h7FF0_0000_0000_0001, 1'b1), 64'hFFF8_0000_0000_0001);
        check("pin_model_flags", {59'd0, flags_model(64'h8000_0000_0000_0001)}, 64'h3);

        repeat (3) @(posedge clk);
        #1;
        check("rst_l1_z", z1, 64'h0);
        check("rst_l1_flags", {59'd0, nan1, inf1, zero1, sub1, sign1}, 64'h4);
        check("rst_l3_z", z3, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        directed(64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 5'b00001, 64'hBFF0_0000_0000_0000);
        directed(64'hC000_0000_0000_0000, 64'h4000_0000_0000_0000, 5'b00000, 64'h4000_0000_0000_0000);
        directed(64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'b00101, 64'h8000_0000_0000_0000);
        directed(64'h0000_0000_0000_0001, 64'h8000_0000_0000_0001, 5'b00011, 64'h8000_0000_0000_0001);
        directed(64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 5'b01001, 64'hFFF0_0000_0000_0000);
        directed(64'h7FF0_0000_0000_0001, 64'hFFF0_0000_0000_0001, 5'b10001, 64'hFFF8_0000_0000_0001);
        directed(64'hFFF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 5'b10000, 64'h7FF8_0000_0000_0000);

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            a = rand_double();
            if (i == 5000) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                check("midrst_l1_z", z1, 64'h0);
                check("midrst_l1_zero", {63'd0, zero1}, 64'h1);
                check("midrst_l3_z", z3, 64'h0);
                check("midrst_l3_zero", {63'd0, zero3}, 64'h1);
                @(negedge clk);
                a = rand_double();
                @(negedge clk);
                rst_n = 1'b1;
                a = 64'h3FF0_0000_0000_0000;
                @(posedge clk);
                #1;
                check("post_rst_l1_z", z1, 64'hBFF0_0000_0000_0000);
                @(negedge clk);
                a = rand_double();
                @(negedge clk);
                a = rand_double();
                @(posedge clk);
                #1;
                check("post_rst_l3_z", z3, 64'hBFF0_0000_0000_0000);
            end
        end

        @(negedge clk);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
